// File: rtl/register_display.sv
// Shadows the CPU's register1Value and scans it in hex onto a multiplexed,
// active-low seven-segment display, with a hold freeze and a change pulse/counter.
module register_display #(
   parameter int REGISTER_WIDTH = 16,
   parameter int DIGITS         = REGISTER_WIDTH / 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLANK_ZEROS    = 1
) (
   input  logic                      clock,
   input  logic                      isReset,
   input  logic [REGISTER_WIDTH-1:0] register1Value,
   input  logic                      hold,
   output logic [DIGITS-1:0]         anode,
   output logic [6:0]                segments,
   output logic                      dp,
   output logic                      changed,
   output logic [7:0]                updateCount
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [REGISTER_WIDTH-1:0] shadow_reg, shadow_next;
   logic [PW-1:0]             prescaler_reg, prescaler_next;
   logic [IW-1:0]             digit_index_reg, digit_index_next;
   logic [7:0]                update_count_reg, update_count_next;
   logic                      changed_reg, changed_next;
   logic [DIGITS-1:0]         anode_reg, anode_next;
   logic [6:0]                segments_reg, segments_next;
   logic                      dp_reg, dp_next;

   logic [3:0]                nibble_of [DIGITS];
   logic [DIGITS-1:0]         blank_digit;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // A digit is blank when it and every more-significant nibble are zero.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nibble_of[gi] = shadow_reg[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign blank_digit[gi] = 1'b0;
         end else begin : g_upper
            assign blank_digit[gi] = (BLANK_ZEROS != 0) &&
                                     (shadow_reg[REGISTER_WIDTH-1:4*gi] == '0);
         end
      end
   endgenerate

   always_comb begin
      shadow_next       = shadow_reg;
      update_count_next = update_count_reg;
      changed_next      = 1'b0;
      if (!hold && (register1Value != shadow_reg)) begin
         shadow_next       = register1Value;
         update_count_next = update_count_reg + 8'd1;
         changed_next      = 1'b1;
      end

      prescaler_next   = prescaler_reg + PW'(1);
      digit_index_next = digit_index_reg;
      if (prescaler_reg == PW'(REFRESH_DIV - 1)) begin
         prescaler_next   = '0;
         digit_index_next = (digit_index_reg == IW'(DIGITS - 1)) ? '0
                                                                 : digit_index_reg + IW'(1);
      end

      // Display stage reads the current index/shadow, so it trails them by a cycle.
      anode_next    = ~(DIGITS'(1) << digit_index_reg);
      segments_next = blank_digit[digit_index_reg] ? 7'h7F : hex7(nibble_of[digit_index_reg]);
      dp_next       = !((digit_index_reg == '0) && hold);
   end

   always_ff @(posedge clock) begin
      if (isReset) begin
         shadow_reg       <= '0;
         prescaler_reg    <= '0;
         digit_index_reg  <= '0;
         update_count_reg <= '0;
         changed_reg      <= 1'b0;
         anode_reg        <= '1;
         segments_reg     <= 7'h7F;
         dp_reg           <= 1'b1;
      end else begin
         shadow_reg       <= shadow_next;
         prescaler_reg    <= prescaler_next;
         digit_index_reg  <= digit_index_next;
         update_count_reg <= update_count_next;
         changed_reg      <= changed_next;
         anode_reg        <= anode_next;
         segments_reg     <= segments_next;
         dp_reg           <= dp_next;
      end
   end

   assign anode       = anode_reg;
   assign segments    = segments_reg;
   assign dp          = dp_reg;
   assign changed     = changed_reg;
   assign updateCount = update_count_reg;

endmodule

// File: tb/tb_register_display.sv
// Directed bench for register_display with a 4-cycle refresh and 16-bit value;
// outputs are sampled on the falling edge, inputs driven right after.
module tb_register_display;

   logic        clk = 1'b0;
   logic        isReset;
   logic        hold;
   logic [15:0] value;
   logic [3:0]  anode;
   logic [6:0]  segments;
   logic        dp;
   logic        changed;
   logic [7:0]  updateCount;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   register_display #(
      .REGISTER_WIDTH(16),
      .DIGITS        (4),
      .REFRESH_DIV   (4),
      .BLANK_ZEROS   (1)
   ) dut (
      .clock         (clk),
      .isReset       (isReset),
      .register1Value(value),
      .hold          (hold),
      .anode         (anode),
      .segments      (segments),
      .dp            (dp),
      .changed       (changed),
      .updateCount   (updateCount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Watch 16 cycles (one full scan) and check each digit against its hand-computed pattern.
   task automatic scan(input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3, input string tag);
      logic [6:0] exp_seg [4];
      int cnt [4];
      int prev;
      int d;
      exp_seg = '{e0, e1, e2, e3};
      cnt     = '{0, 0, 0, 0};
      prev    = -1;
      for (int c = 0; c < 16; c++) begin
         case (anode)
            4'b1110: d = 0;
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            default: d = -1;
         endcase
         check({tag, " anode valid"}, 32'(d >= 0), 32'd1);
         if (d >= 0) begin
            check($sformatf("%s seg digit%0d", tag, d), 32'(segments), 32'(exp_seg[d]));
            check($sformatf("%s dp digit%0d", tag, d), 32'(dp),
                  ((d == 0) && hold) ? 32'd0 : 32'd1);
            if (prev >= 0 && d != prev)
               check({tag, " anode order"}, d, (prev + 1) % 4);
            cnt[d]++;
            prev = d;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++)
         check($sformatf("%s dwell digit%0d", tag, k), cnt[k], 4);
   endtask

   initial begin
      int pulses;
      int found;
      logic [3:0] prev_anode;

      // 1. Reset
      isReset = 1'b1;
      hold    = 1'b0;
      value   = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      check("rst anode", 32'(anode), 32'hF);
      check("rst seg", 32'(segments), 32'h7F);
      check("rst count", 32'(updateCount), 32'd0);
      check("rst changed", 32'(changed), 32'd0);
      check("rst dp", 32'(dp), 32'd1);
      isReset = 1'b0;
      @(negedge clk);
      check("post-rst anode", 32'(anode), 32'hE);
      check("post-rst seg", 32'(segments), 32'h40);
      $display("txn reset: anode=%b seg=%h count=%0d", anode, segments, updateCount);

      // 2. Capture and blanking
      value = 16'h00A5;
      @(negedge clk);
      check("cap changed", 32'(changed), 32'd1);
      check("cap count", 32'(updateCount), 32'd1);
      @(negedge clk);
      check("cap changed drop", 32'(changed), 32'd0);
      scan(7'h12, 7'h08, 7'h7F, 7'h7F, "00A5");
      $display("txn capture 00A5: count=%0d", updateCount);

      // 3. Hold
      hold  = 1'b1;
      value = 16'h1234;
      @(negedge clk);
      check("hold changed", 32'(changed), 32'd0);
      scan(7'h12, 7'h08, 7'h7F, 7'h7F, "hold");
      check("hold count", 32'(updateCount), 32'd1);
      check("hold changed late", 32'(changed), 32'd0);
      hold = 1'b0;
      @(negedge clk);
      check("unhold changed", 32'(changed), 32'd1);
      check("unhold count", 32'(updateCount), 32'd2);
      @(negedge clk);
      check("unhold changed drop", 32'(changed), 32'd0);
      scan(7'h19, 7'h30, 7'h24, 7'h79, "1234");
      $display("txn hold/release 1234: count=%0d", updateCount);

      // 4. Counter wrap after 256 captures from reset
      isReset = 1'b1;
      value   = 16'h0000;
      @(negedge clk);
      isReset = 1'b0;
      @(negedge clk);
      check("wrap start count", 32'(updateCount), 32'd0);
      pulses = 0;
      for (int i = 0; i < 256; i++) begin
         value = 16'(i + 1);
         @(negedge clk);
         if (changed) pulses++;
         @(negedge clk);
         if (changed) pulses++;
         if (i == 0)   check("wrap count 1", 32'(updateCount), 32'd1);
         if (i == 254) check("wrap count 255", 32'(updateCount), 32'd255);
      end
      check("wrap pulses", pulses, 256);
      check("wrap count 0", 32'(updateCount), 32'd0);
      $display("txn wrap: pulses=%0d count=%0d", pulses, updateCount);

      // 5. Reset while digit 2 is active, coinciding with a value change
      prev_anode = anode;
      found      = 0;
      for (int c = 0; c < 64 && found == 0; c++) begin
         @(negedge clk);
         if (anode == 4'b1011 && prev_anode != 4'b1011) found = 1;
         else prev_anode = anode;
      end
      check("midrst find digit2", found, 1);
      isReset = 1'b1;
      value   = 16'hBEEF;
      @(negedge clk);
      check("midrst anode", 32'(anode), 32'hF);
      check("midrst seg", 32'(segments), 32'h7F);
      check("midrst changed", 32'(changed), 32'd0);
      check("midrst count", 32'(updateCount), 32'd0);
      isReset = 1'b0;
      value   = 16'h0000;
      @(negedge clk);
      check("midrst rel anode", 32'(anode), 32'hE);
      check("midrst rel seg", 32'(segments), 32'h40);
      check("midrst rel count", 32'(updateCount), 32'd0);
      check("midrst rel changed", 32'(changed), 32'd0);
      $display("txn mid-scan reset: anode=%b seg=%h count=%0d", anode, segments, updateCount);

      // 6. Full value then all-zero
      value = 16'hFFFF;
      @(negedge clk);
      check("ffff changed", 32'(changed), 32'd1);
      check("ffff count", 32'(updateCount), 32'd1);
      @(negedge clk);
      scan(7'h0E, 7'h0E, 7'h0E, 7'h0E, "FFFF");
      value = 16'h0000;
      @(negedge clk);
      check("zero changed", 32'(changed), 32'd1);
      check("zero count", 32'(updateCount), 32'd2);
      @(negedge clk);
      scan(7'h40, 7'h7F, 7'h7F, 7'h7F, "0000");
      $display("txn FFFF then 0000: count=%0d", updateCount);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
